// File: rtl/bsg_contract_bitmask_pkg.sv
// Shared types and sizing for the buffered bitmask contractor.
package bsg_contract_bitmask_pkg;

  // Depth of the output buffer; the pointer logic in the top assumes exactly two entries.
  localparam int fifo_els_lp = 2;

  // Compressed mask width of the standard configuration.
  localparam int els_default_lp = 16;

  // One buffered result at the standard width: collapsed mask plus per-segment error flags.
  typedef struct packed {
    logic [els_default_lp-1:0] mask;
    logic [els_default_lp-1:0] malformed;
  } entry_s;

endpackage

// File: rtl/bsg_contract_bitmask_core.sv
// Combinational contraction of an expanded mask: one output bit per segment,
// plus a flag per segment whose bits are not all equal.
module bsg_contract_bitmask_core
  import bsg_contract_bitmask_pkg::*;
#(
  parameter int els_p    = 16,
  parameter int expand_p = 32
) (
  input  logic [els_p*expand_p-1:0] data_i,
  output logic [els_p-1:0]          mask_o,
  output logic [els_p-1:0]          malformed_o
);

  for (genvar j = 0; j < els_p; j++) begin : g_seg
    logic [expand_p-1:0] seg;
    assign seg            = data_i[j*expand_p +: expand_p];
    // A segment with any bit set maps to 1; a mix of ones and zeros is malformed.
    assign mask_o[j]      = |seg;
    assign malformed_o[j] = (|seg) & ~(&seg);
  end

endmodule

// File: rtl/bsg_contract_bitmask_buffered.sv
// Contracts expanded byte/word-enable masks, buffers results in a 2-entry
// register FIFO and keeps a saturating count of accepted malformed beats.
module bsg_contract_bitmask_buffered
  import bsg_contract_bitmask_pkg::*;
#(
  parameter int els_p         = 16,
  parameter int expand_p      = 32,
  parameter int count_width_p = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      v_i,
  input  logic [els_p*expand_p-1:0] data_i,
  output logic                      ready_o,
  output logic                      v_o,
  output logic [els_p-1:0]          mask_o,
  output logic [els_p-1:0]          malformed_o,
  input  logic                      yumi_i,
  input  logic                      clear_i,
  output logic [count_width_p-1:0]  err_count_o
);

  typedef struct packed {
    logic [els_p-1:0] mask;
    logic [els_p-1:0] malformed;
  } entry_t;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [count_width_p-1:0] sat_inc(input logic [count_width_p-1:0] v);
    return (v == {count_width_p{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic [els_p-1:0] red_mask;
  logic [els_p-1:0] red_malformed;

  bsg_contract_bitmask_core #(
    .els_p   (els_p),
    .expand_p(expand_p)
  ) core (
    .data_i     (data_i),
    .mask_o     (red_mask),
    .malformed_o(red_malformed)
  );

  entry_t                   mem_r [fifo_els_lp];
  logic                     wr_ptr_r;
  logic                     rd_ptr_r;
  logic                     full_r;
  logic                     empty_r;
  logic [count_width_p-1:0] count_r;
  logic                     enq;
  logic                     deq;
  logic                     bad_beat;

  // ready depends only on state (and reset), never on yumi_i, so a full
  // buffer refuses input even in a cycle where the head is being taken.
  assign ready_o     = ~full_r & ~reset_i;
  assign v_o         = ~empty_r;
  assign enq         = v_i & ready_o;
  assign deq         = yumi_i & ~empty_r;
  assign bad_beat    = |red_malformed;
  assign mask_o      = mem_r[rd_ptr_r].mask;
  assign malformed_o = mem_r[rd_ptr_r].malformed;
  assign err_count_o = count_r;

  // Buffer storage and pointer/flag state; a reset drops everything in flight.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < fifo_els_lp; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (enq) begin
        mem_r[wr_ptr_r] <= '{mask: red_mask, malformed: red_malformed};
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (deq) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      // Occupancy only changes when exactly one side moves.
      if (enq && !deq) begin
        empty_r <= 1'b0;
        full_r  <= (~wr_ptr_r == rd_ptr_r);
      end else if (deq && !enq) begin
        full_r  <= 1'b0;
        empty_r <= (~rd_ptr_r == wr_ptr_r);
      end
    end
  end

  // Malformed-beat counter; clear wins over a coincident increment.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_r <= '0;
    end else if (clear_i) begin
      count_r <= '0;
    end else if (enq && bad_beat) begin
      count_r <= sat_inc(count_r);
    end
  end

  // Consumer may only take an entry that is actually presented.
  assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

  // A refused beat must be re-presented unchanged on the next cycle.
  assert property (@(posedge clk_i) disable iff (reset_i)
                   (v_i && !ready_o) |=> (v_i && $stable(data_i)));

endmodule

// File: tb/tb_bsg_contract_bitmask_buffered.sv
module tb_bsg_contract_bitmask_buffered;

  localparam int ELS = 16;
  localparam int EXP = 32;
  localparam int W   = ELS * EXP;

  logic         clk;
  logic         reset_i;
  logic         v_i;
  logic [W-1:0] data_i;
  logic         ready_o;
  logic         v_o;
  logic [15:0]  mask_o;
  logic [15:0]  malformed_o;
  logic         yumi_i;
  logic         clear_i;
  logic [7:0]   err_count_o;

  int checks = 0;
  int passed = 0;

  // Reference model state: queue of {mask, malformed} and the error count.
  logic [31:0] mq[$];
  int          mcnt = 0;

  bsg_contract_bitmask_buffered #(
    .els_p(ELS), .expand_p(EXP), .count_width_p(8)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i),
    .ready_o(ready_o), .v_o(v_o), .mask_o(mask_o), .malformed_o(malformed_o),
    .yumi_i(yumi_i), .clear_i(clear_i), .err_count_o(err_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Segment-wise classification: zero, all ones, or anything else.
  function automatic logic [31:0] ref_reduce(input logic [W-1:0] d);
    logic [15:0] m;
    logic [15:0] mf;
    logic [31:0] s;
    m  = '0;
    mf = '0;
    for (int j = 0; j < ELS; j++) begin
      s = d[j*EXP +: EXP];
      if (s == 32'h0) begin
        m[j] = 1'b0;
      end else if (s == 32'hFFFF_FFFF) begin
        m[j] = 1'b1;
      end else begin
        m[j]  = 1'b1;
        mf[j] = 1'b1;
      end
    end
    return {m, mf};
  endfunction

  function automatic logic [W-1:0] rand_data(input bit allow_bad);
    logic [W-1:0]  d;
    logic [31:0]   s;
    int unsigned   k;
    for (int j = 0; j < ELS; j++) begin
      k = $urandom_range(0, 3);
      if (k == 0) s = 32'h0;
      else if (k == 1) s = 32'hFFFF_FFFF;
      else if (allow_bad) begin
        s = $urandom;
        if (s == 32'h0 || s == 32'hFFFF_FFFF) s = 32'h0001_0000;
      end else s = (k == 2) ? 32'h0 : 32'hFFFF_FFFF;
      d[j*EXP +: EXP] = s;
    end
    return d;
  endfunction

  function automatic logic [W-1:0] bad_data();
    logic [W-1:0] d;
    d = rand_data(1'b1);
    d[EXP-1:0] = 32'h0000_F00F;
    return d;
  endfunction

  // Advance one clock and update the model from the inputs presented.
  task automatic step();
    bit          enq;
    bit          deq;
    logic [31:0] r;
    enq = v_i && (mq.size() < 2);
    deq = yumi_i && (mq.size() > 0);
    r   = ref_reduce(data_i);
    @(posedge clk);
    #1;
    if (deq) void'(mq.pop_front());
    if (enq) mq.push_back(r);
    if (clear_i) mcnt = 0;
    else if (enq && r[15:0] != 16'h0 && mcnt < 255) mcnt++;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (v_o !== 1'b0) $display("FAIL reset_v_o: got %b expected 0", v_o); else passed++;
    checks++; if (ready_o !== 1'b0) $display("FAIL reset_ready: got %b expected 0", ready_o); else passed++;
    checks++; if (mask_o !== 16'h0) $display("FAIL reset_mask: got %h expected 0000", mask_o); else passed++;
    checks++; if (malformed_o !== 16'h0) $display("FAIL reset_malformed: got %h expected 0000", malformed_o); else passed++;
    checks++; if (err_count_o !== 8'h0) $display("FAIL reset_count: got %0d expected 0", err_count_o); else passed++;
    reset_i = 1'b0;
    #1;
    checks++; if (ready_o !== 1'b1) $display("FAIL release_ready: got %b expected 1", ready_o); else passed++;
    checks++; if (v_o !== 1'b0) $display("FAIL release_v_o: got %b expected 0", v_o); else passed++;
  endtask

  task automatic test_uniform();
    logic [W-1:0] d;
    d = '1;
    d[EXP-1:0] = '0;
    data_i = d; v_i = 1'b1;
    step();
    v_i = 1'b0;
    checks++; if (v_o !== 1'b1) $display("FAIL uniform_v_o: got %b expected 1", v_o); else passed++;
    checks++; if (mask_o !== 16'hFFFE) $display("FAIL uniform_mask: got %h expected fffe", mask_o); else passed++;
    checks++; if (malformed_o !== 16'h0) $display("FAIL uniform_malformed: got %h expected 0000", malformed_o); else passed++;
    checks++; if (err_count_o !== 8'd0) $display("FAIL uniform_count: got %0d expected 0", err_count_o); else passed++;
    yumi_i = 1'b1;
    step();
    yumi_i = 1'b0;
    checks++; if (v_o !== 1'b0) $display("FAIL uniform_drain: got v_o=%b expected 0", v_o); else passed++;
  endtask

  task automatic test_malformed();
    logic [W-1:0] d;
    d = '0;
    d[3*EXP +: EXP] = 32'h0000_00FF;
    data_i = d; v_i = 1'b1;
    step();
    v_i = 1'b0;
    checks++; if (mask_o !== 16'h0008) $display("FAIL malformed_mask: got %h expected 0008", mask_o); else passed++;
    checks++; if (malformed_o !== 16'h0008) $display("FAIL malformed_flags: got %h expected 0008", malformed_o); else passed++;
    checks++; if (err_count_o !== 8'd1) $display("FAIL malformed_count: got %0d expected 1", err_count_o); else passed++;
    yumi_i = 1'b1;
    step();
    yumi_i = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] b [3];
    logic [31:0]  e;
    for (int i = 0; i < 3; i++) b[i] = rand_data(1'b1);
    yumi_i = 1'b0; v_i = 1'b1;
    data_i = b[0]; step();
    checks++; if (ready_o !== 1'b1) $display("FAIL bp_ready_after1: got %b expected 1", ready_o); else passed++;
    data_i = b[1]; step();
    checks++; if (ready_o !== 1'b0) $display("FAIL bp_ready_after2: got %b expected 0", ready_o); else passed++;
    data_i = b[2]; step();
    e = ref_reduce(b[0]);
    checks++; if (ready_o !== 1'b0) $display("FAIL bp_ready_held: got %b expected 0", ready_o); else passed++;
    checks++; if ({mask_o, malformed_o} !== e) $display("FAIL bp_head0: got %h expected %h", {mask_o, malformed_o}, e); else passed++;
    yumi_i = 1'b1; step(); yumi_i = 1'b0;
    e = ref_reduce(b[1]);
    checks++; if (ready_o !== 1'b1) $display("FAIL bp_ready_reopen: got %b expected 1", ready_o); else passed++;
    checks++; if ({mask_o, malformed_o} !== e) $display("FAIL bp_head1: got %h expected %h", {mask_o, malformed_o}, e); else passed++;
    step();
    v_i = 1'b0;
    for (int k = 0; k < 4 && v_o; k++) begin
      checks++;
      if ({mask_o, malformed_o} !== mq[0]) $display("FAIL bp_drain: got %h expected %h", {mask_o, malformed_o}, mq[0]); else passed++;
      yumi_i = 1'b1; step(); yumi_i = 1'b0;
    end
    e = ref_reduce(b[2]);
    checks++; if (v_o !== 1'b0 || mq.size() != 0) $display("FAIL bp_empty: got v_o=%b expected 0", v_o); else passed++;
  endtask

  task automatic test_back_to_back();
    int n_out = 0;
    int bubbles = 0;
    int not_ready = 0;
    for (int cyc = 0; cyc <= 100; cyc++) begin
      v_i    = (cyc < 100);
      data_i = rand_data(1'b1);
      yumi_i = v_o;
      if (v_o) begin
        n_out++;
        checks++;
        if ({mask_o, malformed_o} !== mq[0]) $display("FAIL b2b_data: beat %0d got %h expected %h", n_out, {mask_o, malformed_o}, mq[0]); else passed++;
      end
      step();
      if (cyc < 100 && !v_o) bubbles++;
      if (!ready_o) not_ready++;
    end
    yumi_i = 1'b0;
    checks++; if (n_out != 100) $display("FAIL b2b_outputs: got %0d expected 100", n_out); else passed++;
    checks++; if (bubbles != 0) $display("FAIL b2b_bubbles: got %0d expected 0", bubbles); else passed++;
    checks++; if (not_ready != 0) $display("FAIL b2b_ready_drops: got %0d expected 0", not_ready); else passed++;
    checks++; if (v_o !== 1'b0) $display("FAIL b2b_empty: got v_o=%b expected 0", v_o); else passed++;
    checks++; if (err_count_o !== 8'(mcnt)) $display("FAIL b2b_count: got %0d expected %0d", err_count_o, mcnt); else passed++;
  endtask

  task automatic test_saturation();
    int bad_counts = 0;
    clear_i = 1'b1; step(); clear_i = 1'b0;
    checks++; if (err_count_o !== 8'd0) $display("FAIL sat_clear: got %0d expected 0", err_count_o); else passed++;
    v_i = 1'b1;
    for (int i = 0; i < 300; i++) begin
      data_i = bad_data();
      yumi_i = v_o;
      step();
      if (err_count_o !== 8'((i + 1 > 255) ? 255 : i + 1)) bad_counts++;
      if (i == 253) begin
        checks++; if (err_count_o !== 8'd254) $display("FAIL sat_254: got %0d expected 254", err_count_o); else passed++;
      end
    end
    checks++; if (bad_counts != 0) $display("FAIL sat_ramp: got %0d wrong counts expected 0", bad_counts); else passed++;
    checks++; if (err_count_o !== 8'd255) $display("FAIL sat_final: got %0d expected 255", err_count_o); else passed++;
    data_i = bad_data(); clear_i = 1'b1; yumi_i = v_o;
    step();
    clear_i = 1'b0;
    checks++; if (err_count_o !== 8'd0) $display("FAIL sat_clear_priority: got %0d expected 0", err_count_o); else passed++;
    data_i = bad_data(); yumi_i = v_o;
    step();
    v_i = 1'b0;
    checks++; if (err_count_o !== 8'(mcnt) || mcnt != 1) $display("FAIL sat_restart: got %0d expected 1", err_count_o); else passed++;
    for (int k = 0; k < 4 && v_o; k++) begin
      yumi_i = 1'b1; step(); yumi_i = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    yumi_i = 1'b0; v_i = 1'b1;
    data_i = bad_data(); step();
    data_i = rand_data(1'b1); step();
    v_i = 1'b0;
    checks++; if (v_o !== 1'b1 || ready_o !== 1'b0) $display("FAIL ar_full: got v_o=%b ready=%b expected 1/0", v_o, ready_o); else passed++;
    checks++; if (err_count_o !== 8'(mcnt)) $display("FAIL ar_count_before: got %0d expected %0d", err_count_o, mcnt); else passed++;
    #2;
    reset_i = 1'b1;
    #1;
    mq.delete();
    mcnt = 0;
    checks++; if (v_o !== 1'b0) $display("FAIL ar_v_o: got %b expected 0", v_o); else passed++;
    checks++; if (ready_o !== 1'b0) $display("FAIL ar_ready: got %b expected 0", ready_o); else passed++;
    checks++; if (err_count_o !== 8'd0) $display("FAIL ar_count: got %0d expected 0", err_count_o); else passed++;
    checks++; if (mask_o !== 16'h0 || malformed_o !== 16'h0) $display("FAIL ar_head: got %h/%h expected 0/0", mask_o, malformed_o); else passed++;
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    checks++; if (ready_o !== 1'b1 || v_o !== 1'b0) $display("FAIL ar_release: got ready=%b v_o=%b expected 1/0", ready_o, v_o); else passed++;
    step();
    checks++; if (v_o !== 1'b0 || ready_o !== 1'b1) $display("FAIL ar_idle: got v_o=%b ready=%b expected 0/1", v_o, ready_o); else passed++;
  endtask

  initial begin
    reset_i = 1'b1;
    v_i     = 1'b0;
    yumi_i  = 1'b0;
    clear_i = 1'b0;
    data_i  = '0;
    test_reset();
    test_uniform();
    test_malformed();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
